tc77_serial_reader: RTL and testbench

Reads the TC77 SPI temperature sensor and hands the result to the temperature-sense/fan-control FSM, which sits directly downstream. One transaction is a 16-bit read-only SPI frame. The consumer requests it with the active-low `nLOAD` strobe. The block returns a 14-bit word and a one-cycle active-low `nCOMPLETE` strobe. The word is `TEMPDATA[13]` sign, `TEMPDATA[12:1]` magnitude bits in 0.0625 °C LSB two's complement, and `TEMPDATA[0]` conversion-complete flag.

---
 rtl/tc77_serial_reader.sv | 143 ++++++++++++++
 tb/tb_tc77_serial_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc77_serial_reader.sv
// TC77 SPI temperature reader: issues one 16-bit read-only frame per request
// and presents bits [15:2] of the frame with a one-cycle completion strobe.
module tc77_serial_reader #(
  parameter int CLKDIV = 4,  // SPI half-period in MCLK cycles (>= 2)
  parameter int CSGAP  = 8   // minimum nCS-high time between frames (>= 1)
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        nLOAD,
  output logic [13:0] TEMPDATA,
  output logic        nCOMPLETE,
  output logic        nCS,
  inout  wire         SIO,
  output logic        CLK
);

  localparam int DIV_MAX = (CLKDIV > CSGAP) ? CLKDIV : CSGAP;
  localparam int DW      = $clog2(DIV_MAX + 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] GAP_END = DW'(CSGAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CLK_HI,
    CLK_LO,
    CS_HOLD,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic [13:0] temp_q, temp_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        done_n_q, done_n_d;

  // SIO is only ever read; the block never drives the line.
  assign TEMPDATA  = temp_q;
  assign nCOMPLETE = done_n_q;
  assign nCS       = cs_n_q;
  assign CLK       = sclk_q;

  // Next-state and output decode; every register holds unless its state acts.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    temp_d   = temp_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    done_n_d = 1'b1;  // completion strobe lasts exactly one cycle

    case (state_q)
      IDLE: begin
        if (!nLOAD) begin
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = CS_SETUP;
        end
      end

      // Both setup and low phase end by raising CLK and sampling the bit
      // the TC77 has been presenting since nCS fell / the last CLK fall.
      CS_SETUP, CLK_LO: begin
        if (div_q == DIV_END) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[14:0], SIO};
          bit_d   = bit_q + 5'd1;
          state_d = CLK_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      CLK_HI: begin
        if (div_q == DIV_END) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = (bit_q == 5'd16) ? CS_HOLD : CLK_LO;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      CS_HOLD: begin
        if (div_q == DIV_END) begin
          cs_n_d   = 1'b1;
          temp_d   = shift_q[15:2];
          done_n_d = 1'b0;
          // The nCS-rise cycle itself is the first gap cycle, so the gap
          // counter starts at 1; a one-cycle gap needs no GAP state at all.
          div_d    = DW'(1);
          state_d  = (CSGAP == 1) ? IDLE : GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAP: begin
        if (div_q == GAP_END) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      temp_q   <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      done_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      temp_q   <= temp_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      done_n_q <= done_n_d;
    end
  end

endmodule

// File: tb/tb_tc77_serial_reader.sv
// Bench for tc77_serial_reader: two instances (default and fastest
// parameters), each with a behavioural TC77 shifting out a chosen frame.
module tb_tc77_serial_reader;

  localparam int CA = 4;
  localparam int GA = 8;
  localparam int CB = 2;
  localparam int GB = 1;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: default timing
  logic        nreset_a = 1'b1;
  logic        nload_a  = 1'b1;
  logic [13:0] tempdata_a;
  logic        ncomplete_a, ncs_a, sclk_a;
  logic [15:0] frame_a = 16'h0000;
  logic [15:0] sh_a    = 16'h0000;
  logic        pv_ncs_a = 1'b1, pv_clk_a = 1'b0;
  wire         sio_a;
  assign sio_a = sh_a[15];

  // Instance B: CLKDIV=2, CSGAP=1
  logic        nreset_b = 1'b1;
  logic        nload_b  = 1'b1;
  logic [13:0] tempdata_b;
  logic        ncomplete_b, ncs_b, sclk_b;
  logic [15:0] frame_b = 16'h0000;
  logic [15:0] sh_b    = 16'h0000;
  logic        pv_ncs_b = 1'b1, pv_clk_b = 1'b0;
  wire         sio_b;
  assign sio_b = sh_b[15];

  tc77_serial_reader #(.CLKDIV(CA), .CSGAP(GA)) u_a (
    .MCLK(mclk), .nRESET(nreset_a), .nLOAD(nload_a), .TEMPDATA(tempdata_a),
    .nCOMPLETE(ncomplete_a), .nCS(ncs_a), .SIO(sio_a), .CLK(sclk_a));

  tc77_serial_reader #(.CLKDIV(CB), .CSGAP(GB)) u_b (
    .MCLK(mclk), .nRESET(nreset_b), .nLOAD(nload_b), .TEMPDATA(tempdata_b),
    .nCOMPLETE(ncomplete_b), .nCS(ncs_b), .SIO(sio_b), .CLK(sclk_b));

  // TC77 model: MSB out on nCS fall, next bit on every CLK fall.
  always @(negedge mclk) begin
    if (pv_ncs_a && !ncs_a)                      sh_a <= frame_a;
    else if (!ncs_a && pv_clk_a && !sclk_a)      sh_a <= sh_a << 1;
    pv_ncs_a <= ncs_a;
    pv_clk_a <= sclk_a;
  end

  always @(negedge mclk) begin
    if (pv_ncs_b && !ncs_b)                      sh_b <= frame_b;
    else if (!ncs_b && pv_clk_b && !sclk_b)      sh_b <= sh_b << 1;
    pv_ncs_b <= ncs_b;
    pv_clk_b <= sclk_b;
  end

  // Edge times (MCLK edge numbers) seen during the last observation window
  int rise_q[$], fall_q[$], done_q[$], done_rise_q[$];
  int ncs_fall_q[$], ncs_rise_q[$], tchg_q[$];

  // Drive requests/reset edge by edge and record output transitions
  task automatic observe(input bit b, input int e0, input bit hold,
                         input int p1, input int p2, input int rst_at,
                         input int last);
    logic p_clk, p_ncs, p_done, c_clk, c_ncs, c_done, nl, rs;
    logic [13:0] p_t, c_t;
    rise_q.delete(); fall_q.delete(); done_q.delete(); done_rise_q.delete();
    ncs_fall_q.delete(); ncs_rise_q.delete(); tchg_q.delete();
    p_clk  = b ? sclk_b : sclk_a;
    p_ncs  = b ? ncs_b : ncs_a;
    p_done = b ? ncomplete_b : ncomplete_a;
    p_t    = b ? tempdata_b : tempdata_a;
    while (cyc < last) begin
      nl = !((hold && (cyc + 1 >= e0)) || (cyc + 1 == e0) ||
             (cyc + 1 == p1) || (cyc + 1 == p2));
      rs = !(cyc + 1 == rst_at);
      if (b) begin nload_b = nl; nreset_b = rs; end
      else   begin nload_a = nl; nreset_a = rs; end
      @(negedge mclk);
      c_clk  = b ? sclk_b : sclk_a;
      c_ncs  = b ? ncs_b : ncs_a;
      c_done = b ? ncomplete_b : ncomplete_a;
      c_t    = b ? tempdata_b : tempdata_a;
      if (!p_clk && c_clk)   rise_q.push_back(cyc);
      if (p_clk && !c_clk)   fall_q.push_back(cyc);
      if (p_done && !c_done) done_q.push_back(cyc);
      if (!p_done && c_done) done_rise_q.push_back(cyc);
      if (p_ncs && !c_ncs)   ncs_fall_q.push_back(cyc);
      if (!p_ncs && c_ncs)   ncs_rise_q.push_back(cyc);
      if (c_t !== p_t)       tchg_q.push_back(cyc);
      p_clk = c_clk; p_ncs = c_ncs; p_done = c_done; p_t = c_t;
    end
    if (b) begin nload_b = 1'b1; nreset_b = 1'b1; end
    else   begin nload_a = 1'b1; nreset_a = 1'b1; end
  endtask

  task automatic test_reset();
    nreset_a = 1'b0; nload_a = 1'b0;
    nreset_b = 1'b0; nload_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      n_checks++;
      if ({ncs_a, sclk_a, ncomplete_a} !== 3'b101) $display("FAIL reset_ctl_a: got %b required 101", {ncs_a, sclk_a, ncomplete_a});
      else n_pass++;
      n_checks++;
      if (tempdata_a !== 14'h0000) $display("FAIL reset_data_a: got %h required 0000", tempdata_a);
      else n_pass++;
      n_checks++;
      if ({ncs_b, sclk_b, ncomplete_b, tempdata_b} !== {3'b101, 14'h0000}) $display("FAIL reset_b: got %b/%h required 101/0000", {ncs_b, sclk_b, ncomplete_b}, tempdata_b);
      else n_pass++;
    end
    nreset_a = 1'b1; nload_a = 1'b1;
    nreset_b = 1'b1; nload_b = 1'b1;
    @(negedge mclk);
    $display("reset: done at cycle %0d", cyc);
  endtask

  // One frame; expectations come straight from the timing formulas
  task automatic test_read(input bit b, input logic [15:0] frame, input int dly, input string nm);
    int c, g, e0, got, bad;
    logic [13:0] td, exp_td;
    c = b ? CB : CA;
    g = b ? GB : GA;
    if (b) frame_b = frame; else frame_a = frame;
    e0 = cyc + 1 + dly;
    observe(b, e0, 1'b0, 0, 0, 0, e0 + 33 * c + g + 3);
    exp_td = frame[15:2];
    td = b ? tempdata_b : tempdata_a;

    got = (ncs_fall_q.size() == 1) ? ncs_fall_q[0] - e0 : -1;
    n_checks++;
    if (got !== 0) $display("FAIL %s ncs_fall: got offset %0d required 0", nm, got);
    else n_pass++;

    n_checks++;
    if (rise_q.size() !== 16) $display("FAIL %s clk_rises: got %0d required 16", nm, rise_q.size());
    else n_pass++;

    bad = 0;
    for (int k = 0; k < rise_q.size(); k++) if (rise_q[k] != e0 + c * (2 * k + 1)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL %s clk_rise_time: got %0d misplaced rises required 0", nm, bad);
    else n_pass++;

    bad = (fall_q.size() == 16) ? 0 : 1;
    for (int k = 0; k < fall_q.size(); k++) if (fall_q[k] != e0 + c * (2 * k + 2)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL %s clk_fall_time: got %0d bad falls required 0", nm, bad);
    else n_pass++;

    got = (done_q.size() == 1) ? done_q[0] - e0 : -1;
    n_checks++;
    if (got !== 33 * c) $display("FAIL %s complete_time: got offset %0d required %0d", nm, got, 33 * c);
    else n_pass++;

    got = (done_q.size() == 1 && done_rise_q.size() == 1) ? done_rise_q[0] - done_q[0] : -1;
    n_checks++;
    if (got !== 1) $display("FAIL %s complete_width: got %0d required 1", nm, got);
    else n_pass++;

    got = (ncs_rise_q.size() == 1) ? ncs_rise_q[0] - e0 : -1;
    n_checks++;
    if (got !== 33 * c) $display("FAIL %s ncs_rise: got offset %0d required %0d", nm, got, 33 * c);
    else n_pass++;

    n_checks++;
    if (td !== exp_td) $display("FAIL %s tempdata: got %h required %h", nm, td, exp_td);
    else n_pass++;

    got = (tchg_q.size() == 0) ? 33 * c : ((tchg_q.size() == 1) ? tchg_q[0] - e0 : -1);
    n_checks++;
    if (got !== 33 * c) $display("FAIL %s tempdata_change: got offset %0d required %0d", nm, got, 33 * c);
    else n_pass++;

    $display("read %s: frame=%h tempdata=%h e0=%0d", nm, frame, td, e0);
  endtask

  // Requests mid-frame and mid-gap must be dropped
  task automatic test_ignore();
    int e0;
    frame_a = 16'($urandom);
    e0 = cyc + 1;
    observe(1'b0, e0, 1'b0, e0 + 10, e0 + 33 * CA + 1, 0, e0 + 33 * CA + GA + 20);
    n_checks++;
    if (ncs_fall_q.size() !== 1) $display("FAIL ignore_frames: got %0d frames required 1", ncs_fall_q.size());
    else n_pass++;
    n_checks++;
    if (done_q.size() !== 1) $display("FAIL ignore_completes: got %0d strobes required 1", done_q.size());
    else n_pass++;
    n_checks++;
    if (tempdata_a !== frame_a[15:2]) $display("FAIL ignore_data: got %h required %h", tempdata_a, frame_a[15:2]);
    else n_pass++;
    $display("ignore: frames=%0d completes=%0d", ncs_fall_q.size(), done_q.size());
  endtask

  // nLOAD held low: two frames separated by exactly CSGAP nCS-high cycles
  task automatic test_back_to_back(input bit b);
    int c, g, e0, got;
    c = b ? CB : CA;
    g = b ? GB : GA;
    if (b) frame_b = 16'($urandom); else frame_a = 16'($urandom);
    e0 = cyc + 1;
    observe(b, e0, 1'b1, 0, 0, 0, e0 + 2 * (33 * c + g) - 1);
    got = (done_q.size() >= 1) ? done_q[0] - e0 : -1;
    n_checks++;
    if (got !== 33 * c) $display("FAIL b2b_complete_%0d: got offset %0d required %0d", b, got, 33 * c);
    else n_pass++;
    got = (ncs_fall_q.size() == 2) ? ncs_fall_q[1] - e0 : -1;
    n_checks++;
    if (got !== 33 * c + g) $display("FAIL b2b_second_fall_%0d: got offset %0d required %0d", b, got, 33 * c + g);
    else n_pass++;
    got = (ncs_fall_q.size() == 2 && ncs_rise_q.size() >= 1) ? ncs_fall_q[1] - ncs_rise_q[0] : -1;
    n_checks++;
    if (got !== g) $display("FAIL b2b_gap_%0d: got %0d required %0d", b, got, g);
    else n_pass++;
    n_checks++;
    if (done_q.size() !== 2 || rise_q.size() !== 32) $display("FAIL b2b_counts_%0d: got %0d completes %0d rises required 2 32", b, done_q.size(), rise_q.size());
    else n_pass++;
    $display("back_to_back %0d: e0=%0d frames=%0d", b, e0, ncs_fall_q.size());
  endtask

  // Reset after sample 8, then an immediate request must still work
  task automatic test_reset_mid();
    int e0, rst;
    frame_a = 16'($urandom);
    e0 = cyc + 1;
    rst = e0 + 61;
    observe(1'b0, e0, 1'b0, 0, 0, rst, rst);
    n_checks++;
    if (ncs_rise_q.size() !== 1 || ncs_rise_q[0] !== rst) $display("FAIL midreset_ncs: got %0d rises (first %0d) required 1 at %0d", ncs_rise_q.size(), (ncs_rise_q.size() > 0) ? ncs_rise_q[0] : -1, rst);
    else n_pass++;
    n_checks++;
    if (done_q.size() !== 0) $display("FAIL midreset_complete: got %0d strobes required 0", done_q.size());
    else n_pass++;
    n_checks++;
    if (rise_q.size() !== 8 || sclk_a !== 1'b0) $display("FAIL midreset_clk: got %0d rises clk=%b required 8 clk=0", rise_q.size(), sclk_a);
    else n_pass++;
    n_checks++;
    if (tempdata_a !== 14'h0000) $display("FAIL midreset_data: got %h required 0000", tempdata_a);
    else n_pass++;
    $display("reset_mid: reset at %0d", rst);
    test_read(1'b0, 16'($urandom), 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_read(1'b0, 16'h0C84, 0, "plus25");
    test_read(1'b0, 16'hFB03, 2, "minus10");
    for (int i = 0; i < 4; i++) test_read(1'b0, 16'($urandom), $urandom_range(0, 3), "rand_a");
    test_ignore();
    test_back_to_back(1'b0);
    test_reset_mid();
    for (int i = 0; i < 3; i++) test_read(1'b1, 16'($urandom), $urandom_range(0, 3), "rand_b");
    test_back_to_back(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
